// File: rtl/board_reset_ctrl.sv
`default_nettype none
// board_reset_ctrl: lock/button-driven reset sequencer with staged release and event counter.
// Define WDT_EN to add the wdt_kick_i port and a RUN-state watchdog.
module board_reset_ctrl #(
    parameter int NUM_RST         = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int STRETCH_CYCLES  = 1024,
`ifdef WDT_EN
    parameter int WDT_CYCLES      = 2**24,
`endif
    parameter int RELEASE_GAP     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_n_i,
    input  logic               pll_lock_i,
`ifdef WDT_EN
    input  logic               wdt_kick_i,
`endif
    output logic [NUM_RST-1:0] rst_o,
    output logic               ready_o,
    output logic [7:0]         event_count_o
);

    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int ST_W  = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
    localparam int GAP_W = (RELEASE_GAP > 1) ? $clog2(RELEASE_GAP) : 1;
    localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0]  ST_MAX  = ST_W'(STRETCH_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(RELEASE_GAP - 1);

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        WAIT_LOCK = 3'd1,
        STRETCH   = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] btn_sync;
    logic [SYNC_STAGES-1:0] lock_sync;
    logic                   btn_s;
    logic                   lock_s;
    logic                   btn_db;
    logic                   btn_db_d1;
    logic [DB_W-1:0]        db_cnt;
    logic [ST_W-1:0]        stretch_cnt;
    logic [GAP_W-1:0]       gap_cnt;
    logic                   press;
    logic                   wdt_fire;
    logic                   trigger;

    assign btn_s  = btn_sync[SYNC_STAGES-1];
    assign lock_s = lock_sync[SYNC_STAGES-1];
    assign press  = btn_db_d1 & ~btn_db;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_sync  <= '1;
            lock_sync <= '0;
        end else begin
            btn_sync  <= {btn_sync[SYNC_STAGES-2:0], btn_n_i};
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_lock_i};
        end
    end

    // The debounced level only follows btn_s after DEBOUNCE_CYCLES consecutive mismatches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_db    <= 1'b1;
            btn_db_d1 <= 1'b1;
            db_cnt    <= '0;
        end else begin
            btn_db_d1 <= btn_db;
            if (btn_s == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_MAX) begin
                btn_db <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

`ifdef WDT_EN
    localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_cnt;

    assign wdt_fire = (state == RUN) && !wdt_kick_i && (wdt_cnt == WDT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdt_cnt <= '0;
        end else if ((state != RUN) || wdt_kick_i || trigger) begin
            wdt_cnt <= '0;
        end else begin
            wdt_cnt <= wdt_cnt + 1'b1;
        end
    end
`else
    assign wdt_fire = 1'b0;
`endif

    // Lock loss is not a trigger in WAIT_LOCK: that state is where lock is awaited.
    always_comb begin
        trigger = 1'b0;
        case (state)
            WAIT_LOCK:        trigger = press;
            STRETCH, RELEASE: trigger = press | ~lock_s;
            RUN:              trigger = press | ~lock_s | wdt_fire;
            default:          trigger = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= HOLD;
            rst_o         <= '1;
            ready_o       <= 1'b0;
            event_count_o <= 8'd0;
            stretch_cnt   <= '0;
            gap_cnt       <= '0;
        end else if (trigger) begin
            state   <= HOLD;
            rst_o   <= '1;
            ready_o <= 1'b0;
            if (event_count_o != 8'hFF) begin
                event_count_o <= event_count_o + 8'd1;
            end
        end else begin
            case (state)
                HOLD: begin
                    if (btn_db) begin
                        state <= WAIT_LOCK;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state       <= STRETCH;
                        stretch_cnt <= '0;
                    end
                end
                STRETCH: begin
                    // Bit 0 drops on the transition so it is already low in the first RELEASE cycle.
                    if (stretch_cnt == ST_MAX) begin
                        state   <= RELEASE;
                        gap_cnt <= '0;
                        rst_o   <= rst_o << 1;
                    end else begin
                        stretch_cnt <= stretch_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!rst_o[NUM_RST-1]) begin
                        state   <= RUN;
                        ready_o <= 1'b1;
                    end else if (gap_cnt == GAP_MAX) begin
                        gap_cnt <= '0;
                        rst_o   <= rst_o << 1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                RUN: begin
                    ready_o <= 1'b1;
                end
                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_board_reset_ctrl.sv
`default_nettype none
// tb_board_reset_ctrl: directed and randomized checks of board_reset_ctrl against a phase-level model.
module tb_board_reset_ctrl;

    localparam int N     = 3;
    localparam int SS    = 2;
    localparam int DEB   = 4;
    localparam int STR   = 8;
    localparam int GAP   = 2;
    localparam int WDT_C = 32;
`ifdef WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif
    localparam int OW     = N + 9;
    localparam int RUN_E  = STR + (N - 1) * GAP + 1;
    localparam int M_HOLD = 0;
    localparam int M_WAIT = 1;
    localparam int M_SEQ  = 2;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic btn_n = 1'b1;
    logic lock  = 1'b0;
    logic kick  = 1'b0;
    logic [N-1:0] rst_o;
    logic         ready_o;
    logic [7:0]   event_count_o;
    logic [OW-1:0] dut_out;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Model: sync pipes, debounce run length, and elapsed cycles since the sequence began.
    logic m_bsync [SS];
    logic m_lsync [SS];
    logic m_db, m_dbp;
    int   m_run, m_mode, m_e, m_cnt, m_wdt;

    assign dut_out = {rst_o, ready_o, event_count_o};

    always #5 clk = ~clk;

    board_reset_ctrl #(
        .NUM_RST(N),
        .SYNC_STAGES(SS),
        .DEBOUNCE_CYCLES(DEB),
        .STRETCH_CYCLES(STR),
`ifdef WDT_EN
        .WDT_CYCLES(WDT_C),
`endif
        .RELEASE_GAP(GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_n_i(btn_n),
        .pll_lock_i(lock),
`ifdef WDT_EN
        .wdt_kick_i(kick),
`endif
        .rst_o(rst_o),
        .ready_o(ready_o),
        .event_count_o(event_count_o)
    );

    task automatic model_reset();
        for (int i = 0; i < SS; i++) begin
            m_bsync[i] = 1'b1;
            m_lsync[i] = 1'b0;
        end
        m_db = 1'b1; m_dbp = 1'b1; m_run = 0;
        m_mode = M_HOLD; m_e = 0; m_cnt = 0; m_wdt = 0;
    endtask

    task automatic model_step(input logic b, input logic l, input logic k);
        logic bs, ls, press, in_run, wfire, trig;
        bs     = m_bsync[SS-1];
        ls     = m_lsync[SS-1];
        press  = m_dbp & ~m_db;
        in_run = (m_mode == M_SEQ) && (m_e >= RUN_E);
        wfire  = WDT_ON && in_run && !k && (m_wdt == WDT_C - 1);
        trig   = 1'b0;
        if (m_mode == M_WAIT) trig = press;
        if (m_mode == M_SEQ)  trig = press || !ls || wfire;
        if (!in_run || k || trig) m_wdt = 0;
        else m_wdt = m_wdt + 1;
        if (trig) begin
            m_mode = M_HOLD;
            if (m_cnt < 255) m_cnt = m_cnt + 1;
        end else if (m_mode == M_HOLD && m_db) begin
            m_mode = M_WAIT;
        end else if (m_mode == M_WAIT && ls) begin
            m_mode = M_SEQ;
            m_e = 0;
        end else if (m_mode == M_SEQ && m_e < 1000000) begin
            m_e = m_e + 1;
        end
        m_dbp = m_db;
        if (bs != m_db) begin
            m_run = m_run + 1;
            if (m_run == DEB) begin
                m_db = bs;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        for (int i = SS - 1; i > 0; i--) begin
            m_bsync[i] = m_bsync[i-1];
            m_lsync[i] = m_lsync[i-1];
        end
        m_bsync[0] = b;
        m_lsync[0] = l;
    endtask

    function automatic logic [OW-1:0] model_out();
        logic [N-1:0] r;
        logic rd;
        int cleared;
        r = '1;
        rd = 1'b0;
        if (m_mode == M_SEQ) begin
            if (m_e >= STR) begin
                cleared = (m_e - STR) / GAP + 1;
                if (cleared > N) cleared = N;
                r = r << cleared;
            end
            rd = (m_e >= RUN_E);
        end
        return {r, rd, m_cnt[7:0]};
    endfunction

    task automatic tick(input logic b, input logic l, input logic k);
        btn_n = b; lock = l; kick = k;
        model_step(b, l, k);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tk(input logic b, input logic l);
        tick(b, l, (cyc % 16) == 0);
    endtask

    task automatic test_reset();
        logic [OW-1:0] exp;
        rst = 1'b0; btn_n = 1'b1; lock = 1'b0; kick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp = {{N{1'b1}}, 1'b0, 8'd0};
        n_total++;
        if (dut_out !== exp) $display("FAIL reset_values got=%h want=%h", dut_out, exp);
        else n_pass++;
        model_reset();
        rst = 1'b1;
    endtask

    task automatic test_power_up();
        logic [N-1:0] hist [25];
        int first_rel, first_rdy;
        first_rel = -1; first_rdy = -1;
        for (int i = 1; i <= 24; i++) begin
            tk(1'b1, 1'b1);
            hist[i] = rst_o;
            n_total++;
            if (dut_out !== model_out()) $display("FAIL powerup_model cyc=%0d got=%h want=%h", cyc, dut_out, model_out());
            else n_pass++;
            if (first_rel < 0 && rst_o !== 3'b111) first_rel = i;
            if (first_rdy < 0 && ready_o === 1'b1) first_rdy = i;
        end
        n_total++;
        if (first_rel != SS + 1 + STR) $display("FAIL powerup_first_release got=%0d want=%0d", first_rel, SS + 1 + STR);
        else n_pass++;
        n_total++;
        if ({hist[11], hist[13], hist[15]} !== {3'b110, 3'b100, 3'b000})
            $display("FAIL powerup_staging got=%b,%b,%b want=110,100,000", hist[11], hist[13], hist[15]);
        else n_pass++;
        n_total++;
        if (first_rdy != 16 || event_count_o !== 8'd0)
            $display("FAIL powerup_ready got=%0d cnt=%0d want=16 cnt=0", first_rdy, event_count_o);
        else n_pass++;
    endtask

    task automatic test_button_glitch();
        int c0;
        bit ok;
        c0 = m_cnt;
        repeat (3) begin
            tk(1'b0, 1'b1);
            n_total++;
            if (dut_out !== model_out()) $display("FAIL glitch_short cyc=%0d got=%h want=%h", cyc, dut_out, model_out());
            else n_pass++;
        end
        repeat (12) tk(1'b1, 1'b1);
        n_total++;
        if (ready_o !== 1'b1 || event_count_o !== 8'(c0))
            $display("FAIL glitch_ignored got ready=%b cnt=%0d want ready=1 cnt=%0d", ready_o, event_count_o, c0);
        else n_pass++;
        repeat (6) tk(1'b0, 1'b1);
        repeat (2) tk(1'b1, 1'b1);
        n_total++;
        if (rst_o !== 3'b111 || event_count_o !== 8'(c0 + 1))
            $display("FAIL glitch_press got rst=%b cnt=%0d want rst=111 cnt=%0d", rst_o, event_count_o, c0 + 1);
        else n_pass++;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            tk(1'b1, 1'b1);
            n_total++;
            if (dut_out !== model_out()) $display("FAIL glitch_recover_model cyc=%0d got=%h want=%h", cyc, dut_out, model_out());
            else n_pass++;
            ok = ready_o;
        end
        n_total++;
        if (!ok) $display("FAIL glitch_recover got ready=0 want ready=1");
        else n_pass++;
    endtask

    task automatic test_lock_loss_release();
        int c1;
        bit ok, seen;
        logic [N-1:0] prev;
        logic [OW-1:0] mo;
        tk(1'b1, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            tk(1'b1, 1'b1);
            mo = model_out();
            ok = (mo[OW-1 -: N] == 3'b110);
        end
        c1 = m_cnt;
        seen = 1'b0;
        prev = rst_o;
        repeat (10) begin
            tk(1'b1, 1'b0);
            n_total++;
            if (dut_out !== model_out()) $display("FAIL lockloss_model cyc=%0d got=%h want=%h", cyc, dut_out, model_out());
            else n_pass++;
            if (!seen && rst_o === 3'b111 && prev === 3'b100) seen = 1'b1;
            prev = rst_o;
        end
        n_total++;
        if (!seen || rst_o !== 3'b111 || event_count_o !== 8'(c1 + 1))
            $display("FAIL lockloss_mid_release got seen100=%0d rst=%b cnt=%0d want seen100=1 rst=111 cnt=%0d",
                     seen, rst_o, event_count_o, c1 + 1);
        else n_pass++;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            tk(1'b1, 1'b1);
            n_total++;
            if (dut_out !== model_out()) $display("FAIL lockloss_recover_model cyc=%0d got=%h want=%h", cyc, dut_out, model_out());
            else n_pass++;
            ok = ready_o;
        end
        n_total++;
        if (!ok) $display("FAIL lockloss_recover got ready=0 want ready=1");
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        int c0;
        bit ok;
        c0 = m_cnt;
        for (int i = 0; i < 16; i++) begin
            tk((i < 12) ? 1'b0 : 1'b1, (i >= 4 && i < 14) ? 1'b0 : 1'b1);
            n_total++;
            if (dut_out !== model_out()) $display("FAIL simul_model cyc=%0d got=%h want=%h", cyc, dut_out, model_out());
            else n_pass++;
        end
        n_total++;
        if (rst_o !== 3'b111 || event_count_o !== 8'(c0 + 1))
            $display("FAIL simul_single_count got rst=%b cnt=%0d want rst=111 cnt=%0d", rst_o, event_count_o, c0 + 1);
        else n_pass++;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            tk(1'b1, 1'b1);
            ok = ready_o;
        end
        n_total++;
        if (!ok || event_count_o !== 8'(c0 + 1))
            $display("FAIL simul_recover got ready=%0d cnt=%0d want ready=1 cnt=%0d", ok, event_count_o, c0 + 1);
        else n_pass++;
    endtask

    task automatic test_random();
        int lock_low, btn_low;
        lock_low = 0; btn_low = 0;
        for (int i = 0; i < 1500; i++) begin
            if (lock_low == 0 && $urandom_range(0, 79) == 0) lock_low = $urandom_range(1, 6);
            if (btn_low == 0 && $urandom_range(0, 49) == 0) btn_low = $urandom_range(1, 10);
            tick((btn_low == 0) ? 1'b1 : 1'b0, (lock_low == 0) ? 1'b1 : 1'b0, $urandom_range(0, 24) == 0);
            if (lock_low > 0) lock_low--;
            if (btn_low > 0) btn_low--;
            n_total++;
            if (dut_out !== model_out()) $display("FAIL random_model cyc=%0d got=%h want=%h", cyc, dut_out, model_out());
            else n_pass++;
        end
    endtask

    task automatic test_saturation_async();
        bit ok;
        logic [OW-1:0] exp;
        for (int it = 0; it < 270; it++) begin
            repeat (4) tk(1'b1, 1'b1);
            repeat (3) begin
                tk(1'b1, 1'b0);
                n_total++;
                if (dut_out !== model_out()) $display("FAIL sat_model cyc=%0d got=%h want=%h", cyc, dut_out, model_out());
                else n_pass++;
            end
        end
        n_total++;
        if (event_count_o !== 8'd255) $display("FAIL saturation got=%0d want=255", event_count_o);
        else n_pass++;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tk(1'b1, 1'b1);
            ok = (m_mode == M_SEQ) && (m_e == 3);
        end
        n_total++;
        if (rst_o !== 3'b111 || ready_o !== 1'b0 || !ok)
            $display("FAIL stretch_reached got rst=%b ready=%b ok=%0d want rst=111 ready=0 ok=1", rst_o, ready_o, ok);
        else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        exp = {{N{1'b1}}, 1'b0, 8'd0};
        n_total++;
        if (dut_out !== exp) $display("FAIL async_reset_immediate got=%h want=%h", dut_out, exp);
        else n_pass++;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tk(1'b1, 1'b1);
            n_total++;
            if (dut_out !== model_out()) $display("FAIL post_reset_model cyc=%0d got=%h want=%h", cyc, dut_out, model_out());
            else n_pass++;
            ok = ready_o;
        end
        n_total++;
        if (!ok || event_count_o !== 8'd0)
            $display("FAIL post_reset_run got ready=%0d cnt=%0d want ready=1 cnt=0", ok, event_count_o);
        else n_pass++;
    endtask

`ifdef WDT_EN
    task automatic test_wdt();
        int c0, drop;
        c0 = m_cnt;
        for (int i = 0; i < 100; i++) begin
            tick(1'b1, 1'b1, (i % 20) == 0);
            n_total++;
            if (ready_o !== 1'b1 || dut_out !== model_out())
                $display("FAIL wdt_kicked cyc=%0d got=%h want=%h", cyc, dut_out, model_out());
            else n_pass++;
        end
        tick(1'b1, 1'b1, 1'b1);
        drop = -1;
        for (int j = 1; j <= 55; j++) begin
            tick(1'b1, 1'b1, 1'b0);
            n_total++;
            if (dut_out !== model_out()) $display("FAIL wdt_model cyc=%0d got=%h want=%h", cyc, dut_out, model_out());
            else n_pass++;
            if (drop < 0 && ready_o === 1'b0) drop = j;
        end
        n_total++;
        if (drop != WDT_C) $display("FAIL wdt_timeout got=%0d want=%0d", drop, WDT_C);
        else n_pass++;
        n_total++;
        if (ready_o !== 1'b1 || event_count_o !== 8'(c0 + 1))
            $display("FAIL wdt_recover got ready=%b cnt=%0d want ready=1 cnt=%0d", ready_o, event_count_o, c0 + 1);
        else n_pass++;
    endtask
`endif

    initial begin
        #10000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_power_up();
        test_button_glitch();
        test_lock_loss_release();
        test_simultaneous();
        test_random();
        test_saturation_async();
`ifdef WDT_EN
        test_wdt();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
